// File: rtl/ui_div_arb.sv
// Round-robin arbiter in front of one shared restoring divider (one quotient bit per cycle).
// Responses carry the requester ID and leave over a valid/ready channel.
module ui_div_arb #(
    parameter int unsigned N    = 18,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NREQ-1:0]     req_valid_i,
    input  logic [NREQ*N-1:0]   req_a_i,
    input  logic [NREQ*N-1:0]   req_b_i,
    output logic [NREQ-1:0]     req_ready_o,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [IDW-1:0]      rsp_id_o,
    output logic [N-1:0]        rsp_q_o,
    output logic [N-1:0]        rsp_r_o,
    output logic                rsp_divzero_o,
    output logic                busy_o
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic [N-1:0]   p_q, p_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   b_q, b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dz_q, dz_d;

    logic           gnt_any;
    logic [IDW-1:0] gnt_id;
    int unsigned    arb_sum;
    logic [N-1:0]   a_sel, b_sel;
    logic [N:0]     shift;
    logic [N-1:0]   trial;

    // Search starts one past the last grant and wraps.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        arb_sum = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            arb_sum = 32'(last_q) + k;
            if (arb_sum >= NREQ) begin
                arb_sum = arb_sum - NREQ;
            end
            if (!gnt_any && req_valid_i[arb_sum[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = arb_sum[IDW-1:0];
            end
        end
    end

    assign a_sel = req_a_i[gnt_id*N +: N];
    assign b_sel = req_b_i[gnt_id*N +: N];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    state_d = (b_sel == '0) ? StDone : StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == StIdle && !rst_i && gnt_any) begin
            req_ready_o[gnt_id] = 1'b1;
        end
        rsp_valid_o = (state_q == StDone);
        busy_o      = (state_q != StIdle);
    end

    // P stays below b, so N bits hold it; only the shifted trial needs the extra bit.
    assign shift = {p_q, q_q[N-1]};
    assign trial = shift[N-1:0] - b_q;

    always_comb begin
        last_d = last_q;
        id_d   = id_q;
        p_d    = p_q;
        q_d    = q_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        dz_d   = dz_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    last_d = gnt_id;
                    id_d   = gnt_id;
                    b_d    = b_sel;
                    cnt_d  = '0;
                    if (b_sel == '0) begin
                        q_d  = '1;
                        p_d  = a_sel;
                        dz_d = 1'b1;
                    end else begin
                        q_d  = a_sel;
                        p_d  = '0;
                        dz_d = 1'b0;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q + CW'(1);
                if (shift >= {1'b0, b_q}) begin
                    p_d = trial;
                    q_d = {q_q[N-2:0], 1'b1};
                end else begin
                    p_d = shift[N-1:0];
                    q_d = {q_q[N-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= IDW'(NREQ - 1);
            id_q   <= '0;
            p_q    <= '0;
            q_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            last_q <= last_d;
            id_q   <= id_d;
            p_q    <= p_d;
            q_q    <= q_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            dz_q   <= dz_d;
        end
    end

    assign rsp_id_o      = id_q;
    assign rsp_q_o       = q_q;
    assign rsp_r_o       = p_q;
    assign rsp_divzero_o = dz_q;

endmodule

// File: tb/tb_ui_div_arb.sv
// Randomized bench for ui_div_arb against a transaction-level model:
// round-robin pick, fixed latency per divisor class, results from plain / and %.
module tb_ui_div_arb;

    localparam int N    = 18;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int unsigned MAXV = (1 << N) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_q, rsp_r;
    logic              rsp_divzero, busy;

    always #5 clk = ~clk;

    ui_div_arb #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_ready_o  (req_ready),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_q_o      (rsp_q),
        .rsp_r_o      (rsp_r),
        .rsp_divzero_o(rsp_divzero),
        .busy_o       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: 0 idle, 1 computing, 2 response pending.
    int          m_state = 0;
    int          m_left  = 0;
    int          m_last  = NREQ - 1;
    int unsigned m_a = 0, m_b = 0, m_id = 0;
    bit          m_clean = 1'b1;
    int          gnt_ids[$];
    int          gnt_cyc[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_gnt(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx = (last + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input int unsigned a, input int unsigned b);
        req_a[i*N +: N] = a[N-1:0];
        req_b[i*N +: N] = b[N-1:0];
    endtask

    function automatic int unsigned rand_op();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return $urandom_range(1, 15);
            2:       return MAXV - $urandom_range(0, 3);
            default: return $urandom & MAXV;
        endcase
    endfunction

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic tick();
        int g;
        logic [NREQ-1:0] exp_rdy;
        int unsigned eq, er;
        #1;
        g = model_gnt(req_valid, m_last);
        exp_rdy = '0;
        if (m_state == 0 && !rst && g >= 0) exp_rdy[g] = 1'b1;
        check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
        check_eq("busy", 64'(busy), 64'(m_state != 0));
        check_eq("rsp_valid", 64'(rsp_valid), 64'(m_state == 2));
        if (m_state == 2) begin
            eq = (m_b == 0) ? MAXV : m_a / m_b;
            er = (m_b == 0) ? m_a : m_a % m_b;
            check_eq("rsp_id", 64'(rsp_id), 64'(m_id));
            check_eq("rsp_q", 64'(rsp_q), 64'(eq));
            check_eq("rsp_r", 64'(rsp_r), 64'(er));
            check_eq("rsp_divzero", 64'(rsp_divzero), 64'(m_b == 0));
            if (m_b != 0) begin
                check_eq("q*b+r", 64'(rsp_q) * 64'(m_b) + 64'(rsp_r), 64'(m_a));
                check_eq("r<b", 64'(32'(rsp_r) < m_b), 64'd1);
            end
        end
        if (m_clean) begin
            check_eq("reset_vals", {rsp_id, rsp_q, rsp_r, rsp_divzero}, 64'd0);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                gnt_ids.push_back(i);
                gnt_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_state = 0;
            m_last  = NREQ - 1;
            m_clean = 1'b1;
        end else begin
            case (m_state)
                0: if (g >= 0) begin
                    m_id    = g;
                    m_last  = g;
                    m_a     = 32'(req_a[g*N +: N]);
                    m_b     = 32'(req_b[g*N +: N]);
                    m_clean = 1'b0;
                    m_left  = N;
                    m_state = (m_b == 0) ? 2 : 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_state = 2;
                end
                default: if (rsp_ready) m_state = 0;
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        int unsigned ext_a[3];
        int unsigned ext_b[3];
        ext_a = '{MAXV, 3, MAXV};
        ext_b = '{1, MAXV, MAXV};
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();

        // Single request from requester 0: 100 / 7.
        set_op(0, 100, 7);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (N + 3) tick();

        // Divide by zero from requester 2.
        set_op(2, 5, 0);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (3) tick();

        // Fairness from reset with all requesters valid.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, $urandom & MAXV, $urandom_range(1, MAXV));
        gnt_ids.delete();
        gnt_cyc.delete();
        req_valid = '1;
        repeat (4 * (N + 2) + 2) tick();
        req_valid = '0;
        check_eq("fair_count", 64'(gnt_ids.size()), 64'd5);
        for (int i = 0; i < 5 && i < gnt_ids.size(); i++) begin
            check_eq("fair_order", 64'(gnt_ids[i]), 64'(i % NREQ));
            if (i > 0) check_eq("fair_gap", 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'(N + 2));
        end
        repeat (N + 3) tick();

        // Backpressure: response held while others wait.
        set_op(1, $urandom & MAXV, $urandom_range(1, MAXV));
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        tick();
        req_valid = '1;
        repeat (N + 10) tick();
        rsp_ready = 1'b1;
        tick();
        tick();
        req_valid = '0;
        repeat (N + 3) tick();

        // Width extremes.
        for (int k = 0; k < 3; k++) begin
            set_op(k, ext_a[k], ext_b[k]);
            req_valid = '0;
            req_valid[k] = 1'b1;
            tick();
            req_valid = '0;
            repeat (N + 2) tick();
        end

        // Random sweep with random backpressure.
        repeat (1500) begin
            for (int i = 0; i < NREQ; i++) set_op(i, rand_op(), rand_op());
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (N + 3) tick();

        // Reset in the middle of a computation from requester 3.
        set_op(3, 1000, 3);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gnt_ids.delete();
        req_valid = '1;
        tick();
        check_eq("post_reset_first", 64'(gnt_ids.size() > 0 ? gnt_ids[0] : -1), 64'd0);
        req_valid = '0;
        repeat (N + 3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
